// File: rtl/ir_tx_queue.sv
// ir_tx_queue: byte FIFO feeding a UART-style serializer that drives an IR LED
// with carrier-modulated marks (start = mark, data 0 = mark, stop = space).
module ir_tx_queue #(
  parameter int DEPTH        = 8,
  parameter int BIT_CYCLES   = 2000,
  parameter int CARRIER_HALF = 526
) (
  input  logic       PCLK,
  input  logic       RESET,
  input  logic [7:0] MSG,
  input  logic       ENQUEUE,
  output logic       BUF_FULL,
  output logic       BUF_EMPTY,
  output logic       BUSY,
  output logic       IR_OUT
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CAR_LAST = CW'(CARRIER_HALF - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // FIFO storage and control
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Serializer and carrier state
  logic [1:0]    r_state;
  logic [BW-1:0] r_bit_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [CW-1:0] r_car_cnt;
  logic          r_carrier;
  logic          r_ir;

  logic          w_full;
  logic          w_empty;
  logic          w_wr;
  logic          w_pop;
  logic          w_bit_end;
  logic [1:0]    w_state_nxt;
  logic [BW-1:0] w_bit_cnt_nxt;
  logic [2:0]    w_idx_nxt;
  logic [7:0]    w_shift_nxt;
  logic [CW-1:0] w_car_cnt_nxt;
  logic          w_carrier_nxt;
  logic          w_mark_nxt;

  assign w_full    = (r_count == CNT_FULL);
  assign w_empty   = (r_count == '0);
  // A write landing in an empty FIFO is only visible to the pop a cycle later
  // because the pop looks at the registered count.
  assign w_wr      = ENQUEUE && !w_full;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_bit_end = (r_bit_cnt == BIT_LAST);

  assign BUF_FULL  = w_full;
  assign BUF_EMPTY = w_empty;
  assign BUSY      = (r_state != S_IDLE);
  assign IR_OUT    = r_ir;

  // Next serializer state: bit timer, data bit index and shift register
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_idx_nxt     = r_idx;
    w_shift_nxt   = r_shift;
    if (r_state != S_IDLE) begin
      w_bit_cnt_nxt = w_bit_end ? '0 : (r_bit_cnt + BW'(1));
    end
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_nxt   = S_START;
          w_bit_cnt_nxt = '0;
          w_shift_nxt   = r_mem[r_rd_ptr];
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_idx_nxt   = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      default: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // Next carrier phase; restarted high on every frame start
  always_comb begin
    w_car_cnt_nxt = r_car_cnt;
    w_carrier_nxt = r_carrier;
    if (w_pop) begin
      w_car_cnt_nxt = '0;
      w_carrier_nxt = 1'b1;
    end else if (r_car_cnt == CAR_LAST) begin
      w_car_cnt_nxt = '0;
      w_carrier_nxt = !r_carrier;
    end else begin
      w_car_cnt_nxt = r_car_cnt + CW'(1);
    end
  end

  // Mark level of the bit that will be on the line after this edge
  always_comb begin
    w_mark_nxt = 1'b0;
    case (w_state_nxt)
      S_START: w_mark_nxt = 1'b1;
      S_DATA:  w_mark_nxt = !w_shift_nxt[0];
      default: w_mark_nxt = 1'b0;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + (AW + 1)'(w_wr) - (AW + 1)'(w_pop);
    end
  end

  // FIFO storage and frame shift register carry data only, no reset needed
  always_ff @(posedge PCLK) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= MSG;
    end
    r_shift <= w_shift_nxt;
  end

  // Serializer control, carrier and registered LED drive
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_idx     <= 3'd0;
      r_car_cnt <= '0;
      r_carrier <= 1'b0;
      r_ir      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_car_cnt <= w_car_cnt_nxt;
      r_carrier <= w_carrier_nxt;
      r_ir      <= w_carrier_nxt && w_mark_nxt && (w_state_nxt != S_IDLE);
    end
  end

endmodule
